// File: rtl/tpu_batch_sequencer.sv
// Batch sequencer for a TPU: streams weight and activation bytes into the TPU buffers,
// starts the TPU, waits for completion (with optional timeout), then streams results out.
module tpu_batch_sequencer #(
    parameter int ADDR_W = 8,
    parameter int TMO_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_go,
    input  logic [ADDR_W-1:0] cfg_n_weight,
    input  logic [ADDR_W-1:0] cfg_n_act,
    input  logic [ADDR_W-1:0] cfg_n_result,
    input  logic [TMO_W-1:0]  cfg_timeout,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] tpu_addr,
    output logic [7:0]        tpu_data_out,
    output logic              tpu_write_enable,
    output logic              tpu_sel_weight,
    output logic              tpu_start,
    input  logic [7:0]        tpu_data_in,
    input  logic              tpu_busy,
    input  logic              tpu_done,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_error,
    output logic [3:0]        dbg_state    // current FSM state, 0 = IDLE
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD_W    = 4'd1,
        S_LOAD_A    = 4'd2,
        S_START     = 4'd3,
        S_WAIT_DONE = 4'd4,
        S_RD_ADDR   = 4'd5,
        S_RD_DATA   = 4'd6,
        S_SEND      = 4'd7,
        S_FINISH    = 4'd8
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0] r_n_weight;
    logic [ADDR_W-1:0] r_n_act;
    logic [ADDR_W-1:0] r_n_result;
    logic [TMO_W-1:0]  r_timeout;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_out_data;
    logic              r_we;
    logic              r_sel_weight;
    logic              r_error;

    logic              w_loading;
    logic              w_accept;
    logic              w_load_last;
    logic              w_tmo_hit;
    logic              w_rd_last;
    logic              w_send_hs;
    logic              w_abort;
    logic [ADDR_W-1:0] w_load_count;

    // Both byte streams use valid/ready: a byte moves on a cycle where valid and ready are
    // both high; valid holds its data stable until then, and abort withdraws ready.
    assign w_loading    = (r_state == S_LOAD_W) || (r_state == S_LOAD_A);
    assign w_abort      = abort && (r_state != S_IDLE);
    assign w_accept     = w_loading && in_valid && !abort;
    assign w_load_count = (r_state == S_LOAD_W) ? r_n_weight : r_n_act;
    assign w_load_last  = w_accept && (r_idx == w_load_count - ADDR_ONE);
    assign w_tmo_hit    = (r_timeout != '0) && (r_tmo_cnt == r_timeout - TMO_ONE);
    assign w_rd_last    = (r_idx == r_n_result - ADDR_ONE);
    assign w_send_hs    = (r_state == S_SEND) && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Zero-count phases are skipped in the same transition that would enter them.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cfg_go) begin
                    if (cfg_n_weight != '0)   w_next = S_LOAD_W;
                    else if (cfg_n_act != '0) w_next = S_LOAD_A;
                    else                      w_next = S_START;
                end
            end
            S_LOAD_W: begin
                if (w_load_last) w_next = (r_n_act != '0) ? S_LOAD_A : S_START;
            end
            S_LOAD_A: begin
                if (w_load_last) w_next = S_START;
            end
            S_START: begin
                if (!tpu_busy) w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (tpu_done)       w_next = (r_n_result != '0) ? S_RD_ADDR : S_FINISH;
                else if (w_tmo_hit) w_next = S_FINISH;
            end
            S_RD_ADDR: w_next = S_RD_DATA;
            S_RD_DATA: w_next = S_SEND;
            S_SEND: begin
                if (out_ready) w_next = w_rd_last ? S_FINISH : S_RD_ADDR;
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        tpu_start = 1'b0;
        seq_done  = 1'b0;
        seq_busy  = (r_state != S_IDLE);
        tpu_addr  = r_wr_addr;
        case (r_state)
            S_LOAD_W, S_LOAD_A:   in_ready  = !abort;
            S_START:              tpu_start = !tpu_busy && !abort;
            S_RD_ADDR, S_RD_DATA: tpu_addr  = r_idx;
            S_SEND:               out_valid = 1'b1;
            S_FINISH:             seq_done  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n_weight   <= '0;
            r_n_act      <= '0;
            r_n_result   <= '0;
            r_timeout    <= '0;
            r_tmo_cnt    <= '0;
            r_idx        <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_out_data   <= '0;
            r_we         <= 1'b0;
            r_sel_weight <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_we <= w_accept;
            if (r_state == S_IDLE && cfg_go) begin
                r_n_weight <= cfg_n_weight;
                r_n_act    <= cfg_n_act;
                r_n_result <= cfg_n_result;
                r_timeout  <= cfg_timeout;
                r_error    <= 1'b0;
                r_idx      <= '0;
            end
            if (w_accept) begin
                r_wr_addr    <= r_idx;
                r_wr_data    <= in_data;
                r_sel_weight <= (r_state == S_LOAD_W);
                r_idx        <= w_load_last ? '0 : r_idx + ADDR_ONE;
            end
            if (r_state == S_START) begin
                r_tmo_cnt <= '0;
            end
            // A done arriving on the expiry cycle wins; abort leaves the flag untouched.
            if (r_state == S_WAIT_DONE) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
                if (w_tmo_hit && !tpu_done && !abort) r_error <= 1'b1;
            end
            if (r_state == S_RD_DATA) begin
                r_out_data <= tpu_data_in;
            end
            if (w_send_hs) begin
                r_idx <= w_rd_last ? '0 : r_idx + ADDR_ONE;
            end
            if (w_abort) begin
                r_idx <= '0;
            end
        end
    end

    assign out_data         = r_out_data;
    assign tpu_data_out     = r_wr_data;
    assign tpu_write_enable = r_we;
    assign tpu_sel_weight   = r_sel_weight;
    assign seq_error        = r_error;
    assign dbg_state        = r_state;

endmodule

// File: doc/tpu_batch_sequencer.md
TPU_BATCH_SEQUENCER -- requirements
Module: tpu_batch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: TPU buffer address width.
REQ-002 SHALL have parameter TMO_W, default 16: timeout counter width.
REQ-003 clk  in  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 cfg_go  in  1  one-cycle start request.
REQ-006 cfg_n_weight / cfg_n_act / cfg_n_result  in  ADDR_W each  byte counts per phase; 0 skips the phase.
REQ-007 cfg_timeout  in  TMO_W  max cycles waiting for tpu_done; 0 disables the timeout.
REQ-008 abort  in  1  synchronous abort.
REQ-009 in_data  in  8, in_valid  in  1, in_ready  out  1: load byte stream.
REQ-010 out_data  out  8, out_valid  out  1, out_ready  in  1: result byte stream.
REQ-011 tpu_addr  out  ADDR_W, tpu_data_out  out  8, tpu_write_enable  out  1, tpu_sel_weight  out  1 (1 = weight buffer, 0 = activation buffer).
REQ-012 tpu_start  out  1, tpu_data_in  in  8, tpu_busy  in  1, tpu_done  in  1.
REQ-013 seq_busy  out  1, seq_done  out  1 (pulse), seq_error  out  1 (sticky timeout flag).

Function
REQ-014 States SHALL be IDLE, LOAD_W, LOAD_A, START, WAIT_DONE, RD_ADDR, RD_DATA, SEND, FINISH.
REQ-015 In IDLE, cfg_go SHALL latch all cfg_* inputs, clear seq_error, clear the address counter and go to LOAD_W; cfg_go outside IDLE SHALL be ignored.
REQ-016 seq_busy SHALL be 1 in every state except IDLE.
REQ-017 Entering any phase whose latched count is 0 SHALL be skipped in the same transition, with no write, start or read issued for that phase.
REQ-018 In LOAD_W and LOAD_A, in_ready SHALL be 1; otherwise it SHALL be 0.
REQ-019 On each in_valid&&in_ready, the next cycle SHALL give tpu_write_enable=1 for exactly one cycle, with tpu_data_out=in_data, tpu_addr=phase index (starting at 0) and tpu_sel_weight=1 in LOAD_W, 0 in LOAD_A.
REQ-020 After the byte with index count-1 is accepted, the address counter SHALL reset to 0 and the FSM SHALL advance (LOAD_W->LOAD_A->START).
REQ-021 START SHALL pulse tpu_start for one cycle, clear the timeout counter and go to WAIT_DONE.
REQ-022 If tpu_busy=1 in START, tpu_start SHALL be withheld and the FSM SHALL remain in START until tpu_busy=0.
REQ-023 WAIT_DONE SHALL increment the timeout counter each cycle.
REQ-024 In WAIT_DONE, tpu_done=1 SHALL go to RD_ADDR (or FINISH if cfg_n_result=0).
REQ-025 With cfg_timeout!=0 and counter==cfg_timeout-1 and tpu_done=0, the FSM SHALL set seq_error=1 and go to FINISH.
REQ-026 If tpu_done and timeout expiry coincide, done SHALL win and seq_error SHALL stay 0.
REQ-027 RD_ADDR SHALL drive tpu_addr=result index; RD_DATA SHALL capture tpu_data_in (one-cycle read latency) into out_data, set out_valid=1 and go to SEND.
REQ-028 In SEND, out_valid and out_data SHALL hold stable until out_ready=1.
REQ-029 On the SEND handshake, out_valid SHALL drop the next cycle and the FSM SHALL go to RD_ADDR with index+1, or to FINISH after index cfg_n_result-1.
REQ-030 FINISH SHALL pulse seq_done for one cycle and return to IDLE.
REQ-031 abort=1 in any non-IDLE state SHALL return the FSM to IDLE next cycle and deassert in_ready, out_valid, tpu_write_enable and tpu_start, without pulsing seq_done and with seq_error unchanged.
REQ-032 rst_n has priority over abort.
REQ-033 Counters SHALL be ADDR_W bits; count 255 (ADDR_W=8) SHALL address 0..254 with no wrap into a repeated address.

Reset
REQ-034 While rst_n=0 at a clock edge, next state SHALL be IDLE, with counters, tpu_addr, tpu_data_out and out_data =0.
REQ-035 While rst_n=0 at a clock edge, in_ready, out_valid, tpu_write_enable, tpu_sel_weight, tpu_start, seq_busy, seq_done and seq_error SHALL be 0.
REQ-036 Reset asserted mid-phase SHALL discard all latched config; no partial write or start SHALL follow release.

Verification
REQ-037 Bench SHALL cover a nominal run: go with counts 2/2/2, bytes 11,22,33,44, done after 5 cycles, results AA,BB -> writes w@0=11, w@1=22, a@0=33, a@1=44; one tpu_start; out bytes AA,BB; seq_done pulse; seq_error=0.
REQ-038 Bench SHALL cover timeout: cfg_timeout=10, tpu_done never asserted -> seq_error=1 at cycle 10 of WAIT_DONE, seq_done pulse, no reads issued.
REQ-039 Bench SHALL cover backpressure: out_ready low for 7 cycles in SEND -> out_data and out_valid stable for all 7 cycles, byte emitted exactly once.
REQ-040 Bench SHALL cover zero counts: cfg_n_weight=0, cfg_n_result=0 -> no weight writes, no reads, seq_done one cycle after tpu_done.
REQ-041 Bench SHALL cover abort: abort after 1 of 3 activation bytes -> IDLE next cycle, no tpu_start, no seq_done; a following cfg_go restarts at address 0.
REQ-042 Bench SHALL cover coincidence: tpu_done coincident with timeout expiry -> reads proceed and seq_error=0.
